// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I control unit: sequences each instruction through its states and drives
// the datapath enables, mux selects, immediate format and ALU operation.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR,
    StExecI, StAluWb, StBranch, StJal, StJalrPc, StLui
  } state_e;

  state_e state_q, state_d;

  // Shared funct3 -> ALU operation map for R-type and OP-IMM.
  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_op = sub ? 3'b001 : 3'b000;
      3'b100:  alu_op = 3'b100;
      3'b110:  alu_op = 3'b011;
      3'b111:  alu_op = 3'b010;
      3'b010:  alu_op = 3'b101;
      3'b011:  alu_op = 3'b110;
      default: alu_op = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StFetch;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpReg:           state_d = StExecR;
          OpImm, OpJalr:   state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpLui:           state_d = StLui;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = (op == OpJalr) ? StJalrPc : StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJal:      state_d = StAluWb;
      StJalrPc:   state_d = StAluWb;
      StLui:      state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    RegWrite   = 1'b0;

    case (op)
      OpLoad, OpImm, OpJalr: ImmSrc = 3'b000;
      OpStore:               ImmSrc = 3'b001;
      OpBranch:              ImmSrc = 3'b010;
      OpJal:                 ImmSrc = 3'b011;
      OpLui:                 ImmSrc = 3'b100;
      default:               ImmSrc = 3'b000;
    endcase

    unique case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op(funct3, funct7[5]);
      end
      StExecI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = (op == OpJalr) ? 3'b000 : alu_op(funct3, 1'b0);
      end
      StAluWb: RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA = 2'b10;
        case (funct3[2:1])
          2'b10:   ALUControl = 3'b101;
          2'b11:   ALUControl = 3'b110;
          default: ALUControl = 3'b001;
        endcase
        // beq/bge/bgeu take on Zero=1; bne/blt/bltu take on Zero=0.
        PCWrite = funct3[2] ? (Zero == funct3[0]) : (Zero != funct3[0]);
      end
      StJal, StJalrPc: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      StLui: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: walks each instruction class cycle by cycle and
// compares the packed control word against hand-derived expectations.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0000000;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite)
  );

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite}
  logic [16:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
                ImmSrc, RegWrite};

  function automatic logic [16:0] cw(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [2:0] imm, input logic rw);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw};
  endfunction

  function automatic logic [16:0] w_fetch(input logic [2:0] imm);
    return cw(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
  endfunction

  function automatic logic [16:0] w_decode(input logic [2:0] imm);
    return cw(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0);
  endfunction

  function automatic logic [16:0] w_aluwb(input logic [2:0] imm);
    return cw(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1);
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [16:0] exp);
    @(negedge clk);
    chk(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    op = o;
    funct3 = f3;
    funct7 = f7;
    Zero = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc("reset_hold", w_fetch(3'b000));
    rst = 1'b1;

    // add then sub
    instr(7'b0110011, 3'b000, 7'b0000000);
    cyc("add_fetch", w_fetch(3'b000));
    cyc("add_decode", w_decode(3'b000));
    cyc("add_execr", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0));
    cyc("add_aluwb", w_aluwb(3'b000));
    instr(7'b0110011, 3'b000, 7'b0100000);
    cyc("sub_fetch", w_fetch(3'b000));
    cyc("sub_decode", w_decode(3'b000));
    cyc("sub_execr", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
    cyc("sub_aluwb", w_aluwb(3'b000));
    instr(7'b0110011, 3'b011, 7'b0000000);
    cyc("sltu_fetch", w_fetch(3'b000));
    cyc("sltu_decode", w_decode(3'b000));
    cyc("sltu_execr", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b110, 3'b000, 0));
    cyc("sltu_aluwb", w_aluwb(3'b000));

    // addi with funct7[5] set must still add; andi maps to and
    instr(7'b0010011, 3'b000, 7'b0100000);
    cyc("addi_fetch", w_fetch(3'b000));
    cyc("addi_decode", w_decode(3'b000));
    cyc("addi_execi", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
    cyc("addi_aluwb", w_aluwb(3'b000));
    instr(7'b0010011, 3'b111, 7'b0000000);
    cyc("andi_fetch", w_fetch(3'b000));
    cyc("andi_decode", w_decode(3'b000));
    cyc("andi_execi", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 0));
    cyc("andi_aluwb", w_aluwb(3'b000));

    // lw then sw
    instr(7'b0000011, 3'b010, 7'b0000000);
    cyc("lw_fetch", w_fetch(3'b000));
    cyc("lw_decode", w_decode(3'b000));
    cyc("lw_memadr", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
    cyc("lw_memread", cw(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    cyc("lw_memwb", cw(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1));
    instr(7'b0100011, 3'b010, 7'b0000000);
    cyc("sw_fetch", w_fetch(3'b001));
    cyc("sw_decode", w_decode(3'b001));
    cyc("sw_memadr", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
    cyc("sw_memwrite", cw(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));

    // branches: Zero driven only in the BRANCH cycle
    instr(7'b1100011, 3'b000, 7'b0000000);
    cyc("beq_t_fetch", w_fetch(3'b010));
    cyc("beq_t_decode", w_decode(3'b010));
    Zero = 1'b1;
    cyc("beq_t_branch", cw(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0));
    instr(7'b1100011, 3'b000, 7'b0000000);
    cyc("beq_n_fetch", w_fetch(3'b010));
    cyc("beq_n_decode", w_decode(3'b010));
    cyc("beq_n_branch", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0));
    instr(7'b1100011, 3'b100, 7'b0000000);
    cyc("blt_fetch", w_fetch(3'b010));
    cyc("blt_decode", w_decode(3'b010));
    cyc("blt_branch", cw(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 3'b010, 0));
    instr(7'b1100011, 3'b111, 7'b0000000);
    cyc("bgeu_fetch", w_fetch(3'b010));
    cyc("bgeu_decode", w_decode(3'b010));
    cyc("bgeu_branch", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b110, 3'b010, 0));
    instr(7'b1100011, 3'b001, 7'b0000000);
    cyc("bne_fetch", w_fetch(3'b010));
    cyc("bne_decode", w_decode(3'b010));
    Zero = 1'b1;
    cyc("bne_branch", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0));

    // jal, jalr, lui
    instr(7'b1101111, 3'b000, 7'b0000000);
    cyc("jal_fetch", w_fetch(3'b011));
    cyc("jal_decode", w_decode(3'b011));
    cyc("jal_jal", cw(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0));
    cyc("jal_aluwb", w_aluwb(3'b011));
    instr(7'b1100111, 3'b000, 7'b0000000);
    cyc("jalr_fetch", w_fetch(3'b000));
    cyc("jalr_decode", w_decode(3'b000));
    cyc("jalr_execi", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
    cyc("jalr_pc", cw(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0));
    cyc("jalr_aluwb", w_aluwb(3'b000));
    instr(7'b0110111, 3'b000, 7'b0000000);
    cyc("lui_fetch", w_fetch(3'b100));
    cyc("lui_decode", w_decode(3'b100));
    cyc("lui_lui", cw(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1));

    // illegal opcode returns straight to FETCH
    instr(7'b0000000, 3'b000, 7'b0000000);
    cyc("ill_fetch", w_fetch(3'b000));
    cyc("ill_decode", w_decode(3'b000));

    // lw abandoned by reset in MEMREAD
    instr(7'b0000011, 3'b010, 7'b0000000);
    cyc("mr_fetch", w_fetch(3'b000));
    cyc("mr_decode", w_decode(3'b000));
    cyc("mr_memadr", cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
    #2 rst = 1'b0;
    #1 chk("mr_async_rst", obs, w_fetch(3'b000));
    cyc("mr_rst_held", w_fetch(3'b000));
    rst = 1'b1;
    cyc("mr_no_memwb", w_fetch(3'b000));
    cyc("mr_redecode", w_decode(3'b000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Control unit for the multi-cycle RV32I datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath's register enables, mux selects, immediate format and ALU operation. It replaces the single-cycle control path. Memory is one shared combinational instruction/data memory, so each access takes one state.

## Interface
Parameters:
- none. The encodings listed below are fixed.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7  in  7  Instr[31:25]
- Zero  in  1  ALU result == 0 (combinational, current cycle)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  enables the Instr and OldPC registers
- ResultSrc  out  2  Result select: 00 ALUOut, 01 Data (MDR), 10 ALUResult, 11 ImmExt
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 RD1 (A register)
- ALUSrcB  out  2  ALU B select: 00 WriteData (RD2), 01 ImmExt, 10 constant 4
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- RegWrite  out  1  register file write enable

## Operation
- **State register.** 4-bit. States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR_PC, LUI.
- **Default outputs.** Every enable is 0 and every select is 0 unless a state below sets it.
- **ImmSrc** is decoded from `op` only, in every state:
  - I for lw (0000011), OP-IMM (0010011) and jalr (1100111)
  - S for 0100011
  - B for 1100011
  - J for 1101111
  - U for 0110111
  - 000 otherwise
- **FETCH:** AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1 (PC <= PC+4). Next state is DECODE.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, add, so ALUOut <= OldPC+imm (branch/jal target). Next state by `op`:
  - lw/sw → MEMADR
  - R-type (0110011) → EXECR
  - OP-IMM → EXECI
  - jalr → EXECI
  - branch → BRANCH
  - jal → JAL
  - lui → LUI
  - any other opcode → FETCH, with no register or memory write
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, add. Next state is MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD:** ResultSrc=00, AdrSrc=1. Next state is MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1. Next state is FETCH.
- **MEMWRITE:** ResultSrc=00, AdrSrc=1, MemWrite=1. Next state is FETCH.
- **EXECR:** ALUSrcA=10, ALUSrcB=00. ALUControl by funct3:
  - 000: sub if funct7[5]=1, else add
  - 100: xor
  - 110: or
  - 111: and
  - 010: slt
  - 011: sltu
  - any other funct3: add
  - Next state is ALUWB.
- **EXECI:** ALUSrcA=10, ALUSrcB=01.
  - For jalr: add, next state JALR_PC.
  - Otherwise: ALUControl by the same funct3 map with funct7 ignored, next state ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1. Next state is FETCH.
- **BRANCH:** ALUSrcA=10, ALUSrcB=00, ResultSrc=00.
  - beq (000) / bne (001): sub. Taken if Zero=1 (beq) or Zero=0 (bne).
  - blt (100) / bge (101): slt. Taken if Zero=0 (blt) or Zero=1 (bge).
  - bltu (110) / bgeu (111): sltu. Same Zero rule as blt/bge.
  - PCWrite is 1 only when taken (combinational on Zero). Next state is FETCH.
- **JAL:** ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (PC <= target in ALUOut; ALUOut <= OldPC+4). Next state is ALUWB.
- **JALR_PC:** ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (PC <= rs1+imm). Next state is ALUWB. The target LSB is not cleared.
- **LUI:** ResultSrc=11, RegWrite=1. Next state is FETCH.

## Timing
- **Reset.** rst=0 forces the state to FETCH immediately, without waiting for a clock edge. While reset is held, the outputs are the FETCH values: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10, MemWrite=0, RegWrite=0.
  - The datapath registers share the same reset, so these enables have no effect while reset is held.
  - Reset asserted mid-instruction abandons that instruction. No partial write is issued after reset is asserted.
- **Output type.** Outputs are Moore in the state, except:
  - ALUControl (depends on funct3/funct7)
  - PCWrite in BRANCH (depends on Zero)
  - ImmSrc (depends on op)
- **Input stability.** op, funct3 and funct7 come from the Instr register and are stable from DECODE through the end of the instruction.
- **Cycles per instruction:**
  - lw: 5
  - sw: 4
  - R-type / I-type ALU: 4
  - branch: 3 (taken or not)
  - jal: 4
  - jalr: 5
  - lui: 3
  - illegal opcode: 2
- **Write-enable exclusivity.** At most one of MemWrite and RegWrite is high in any cycle. MemWrite and RegWrite are each high for exactly one cycle per instruction that writes.

## Test plan
1. **Reset.** Hold rst=0 for 3 cycles, then release. Required: FETCH outputs while held; the first rising edge after release enters DECODE.
2. **add x3,x1,x2** (op 0110011, funct3 000, funct7 0000000). Required: state sequence FETCH, DECODE, EXECR, ALUWB; ALUControl=000 in EXECR; RegWrite=1 only in cycle 4. Repeat with funct7=0100000: ALUControl=001.
3. **lw then sw.** lw: 5 cycles, MemWrite never 1, RegWrite=1 in MEMWB with ResultSrc=01. sw: 4 cycles, MemWrite=1 in cycle 4 with AdrSrc=1, ImmSrc=001.
4. **beq** with Zero=1 in BRANCH: PCWrite=1, ALUControl=001. **beq** with Zero=0: PCWrite=0. **blt** with Zero=0: ALUControl=101, PCWrite=1. Each takes 3 cycles.
5. **jal and jalr.** jal: PCWrite=1 in JAL with ResultSrc=00, then RegWrite=1 in ALUWB, 4 cycles total. jalr: EXECI, JALR_PC, ALUWB, 5 cycles total.
6. **Illegal opcode and mid-instruction reset.** op=0000000: DECODE goes to FETCH, no writes issued. Assert rst in MEMREAD: the state is FETCH in the same cycle and no MEMWB write occurs.
